metadata_egress_queue: RTL and testbench
========================================

# metadata_egress_queue

Buffers completed per-frame metadata records from the metadata packager and presents them to the downstream consumer (flow lookup / host DMA) over a valid/ready handshake. Captures one `eth_metadata_t` record on each rising edge of the packager's level-style `metadata_valid`. Holds records in a small circular FIFO, drops records when full, and counts accepted and dropped records.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries. Power of two, ≥2.
- `CNT_W`, 16: width of the statistics counters.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset; synchronous, active-low
- `metadata`  in  `$bits(eth_metadata_t)`  record from packager (`eth_metadata_t`, `eth_parser_pkg`)
- `metadata_valid`  in  1  level; high from record completion until frame end
- `m_metadata`  out  `eth_metadata_t`  head-of-queue record
- `m_valid`  out  1  head record valid
- `m_ready`  in  1  consumer accepts head
- `occupancy`  out  `$clog2(DEPTH)+1`  entries currently held
- `full`  out  1  `occupancy == DEPTH`
- `accepted_count`  out  CNT_W  records written, saturating
- `drop_count`  out  CNT_W  records dropped, saturating
- `overflow`  out  1  sticky; set on first drop, cleared only by reset

## Operation
- Edge detect: register `mv_q <= metadata_valid`. `capture = metadata_valid & ~mv_q`. Exactly one capture per high period, independent of its length. `mv_q` resets to 0, so `metadata_valid` high in the first cycle after reset counts as one capture.
- Pop: `pop = m_valid & m_ready`. The head advances at the clock edge.
- Push: `push = capture & (~full | pop)`. When full, a simultaneous pop frees the slot, so the record is written.
- Drop: `capture & full & ~pop`. No write. `drop_count` increments (saturating) and `overflow` sets.
- Storage: `DEPTH` entries with write pointer `wr_ptr` and read pointer `rd_ptr`, each `$clog2(DEPTH)` bits. Pointers wrap modulo DEPTH.
- Occupancy: `occupancy` is a separate counter. It does +1 on push only, −1 on pop only, and is unchanged when push and pop occur together.
- Outputs: `m_metadata = mem[rd_ptr]` (combinational read of the registered array). `m_valid = (occupancy != 0)`.
- Empty queue: a capture into an empty queue cannot be popped in the same cycle, because `m_valid` is 0. The record appears at the next edge.
- Counters: `accepted_count` increments on each push and holds at `2^CNT_W−1`. `drop_count` behaves the same way on each drop.
- Handshake rules:
  - `m_metadata` is stable while `m_valid & ~m_ready`.
  - `m_valid` never deasserts without a pop.
  - Records leave in capture order.
- Reset: synchronous. All of the following go to 0 at the first `clk` edge with `rst_n`=0, including mid-transfer:
  - pointers, `occupancy`, `mv_q`, `m_valid`, `full`, both counters, `overflow`
  - `m_metadata` reads `mem[0]`; memory contents need not be cleared.

## Timing
- Capture latency: `metadata_valid` rises in the cycle sampled at edge N. The record is written at edge N, and `m_valid`=1 with that record from edge N onward (visible in the cycle after N).
- Throughput: one push and one pop per cycle, sustained.
- `full`, `occupancy`, `overflow` and the counters are all registered. Each reflects the same edge's push/pop/drop decision.
- The `metadata` input is sampled only in the capture cycle. Later changes while `metadata_valid` stays high are ignored.

## Test plan
- **Basic capture and pop:** reset, then pulse `metadata_valid` high for 3 cycles with `dest_mac`=0x0011_2233_4455 and `m_ready`=1.
  - Required: exactly one record out with that MAC.
  - Required: `accepted_count`=1, `occupancy` returns to 0.
- **Level hold:** keep `metadata_valid` high for 20 cycles.
  - Required: exactly one capture and `accepted_count`=1.
- **Fill and drop:** with `m_ready`=0 and DEPTH=4, send 6 separate rising edges with records 1..6.
  - Required: `full`=1 after the 4th, `drop_count`=2, `overflow`=1.
  - Then raise `m_ready`. Required: records 1,2,3,4 drain in order, then `m_valid`=0.
- **Full with simultaneous pop:** queue full, `m_ready`=1, and a capture in the same cycle.
  - Required: the record is accepted, `drop_count` unchanged, `occupancy` stays 4.
- **Wrap-around and backpressure:** 10 records with `m_ready` toggling 1,0,1,0.
  - Required: all 10 received in order with no drops.
  - Required: `m_metadata` stable during each `m_ready`=0 cycle.
- **Reset mid-operation:** 3 records queued, `overflow`=1; assert `rst_n`=0 for one edge.
  - Required next cycle: `m_valid`=0, `occupancy`=0, both counters 0, `overflow`=0.
  - Required: if `metadata_valid` is held high across reset, exactly one capture follows reset release.

Source files
------------

// File: rtl/eth_parser_pkg.sv
// Shared record types for the Ethernet parser path.
// eth_metadata_t is the per-frame record built by the packager.
package eth_parser_pkg;

    typedef struct packed {
        logic [47:0] dest_mac;
        logic [47:0] src_mac;
        logic [15:0] ethertype;
        logic [15:0] frame_len;
    } eth_metadata_t;

endpackage

// File: rtl/metadata_egress_queue.sv
// Small circular FIFO for per-frame metadata records, with a valid/ready output.
// Captures one record per rising edge of metadata_valid and keeps accept/drop statistics.
module metadata_egress_queue
    import eth_parser_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  eth_metadata_t              metadata,
    input  logic                       metadata_valid,
    output eth_metadata_t              m_metadata,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       full,
    output logic [CNT_W-1:0]           accepted_count,
    output logic [CNT_W-1:0]           drop_count,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    eth_metadata_t      mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   drop_q, drop_d;
    logic               ovf_q, ovf_d;
    logic               mv_q;
    logic               capture, pop, push, drop;

    assign full       = (occ_q == OCC_FULL);
    assign m_valid    = (occ_q != '0);
    assign m_metadata = mem_q[rd_ptr_q];
    assign occupancy      = occ_q;
    assign accepted_count = acc_q;
    assign drop_count     = drop_q;
    assign overflow       = ovf_q;

    // A pop in the same cycle frees the head slot, so a capture into a full queue still lands.
    always_comb begin
        capture = metadata_valid & ~mv_q;
        pop     = m_valid & m_ready;
        push    = capture & (~full | pop);
        drop    = capture & full & ~pop;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        acc_d    = acc_q;
        drop_d   = drop_q;
        ovf_d    = ovf_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        if (push && acc_q != '1)  acc_d  = acc_q + CNT_W'(1);
        if (drop && drop_q != '1) drop_d = drop_q + CNT_W'(1);
        if (drop)                 ovf_d  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mv_q     <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            acc_q    <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            mv_q     <= metadata_valid;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            acc_q    <= acc_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is deliberately not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && push) mem_q[wr_ptr_q] <= metadata;
    end

endmodule

// File: tb/tb_metadata_egress_queue.sv
// Self-checking bench for metadata_egress_queue: directed scenarios plus a
// randomized run checked against a queue-based reference model.
module tb_metadata_egress_queue;
    import eth_parser_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    eth_metadata_t         metadata = '0;
    logic                  metadata_valid = 1'b0;
    eth_metadata_t         m_metadata;
    logic                  m_valid;
    logic                  m_ready = 1'b0;
    logic [$clog2(DEPTH):0] occupancy;
    logic                  full;
    logic [CNT_W-1:0]      accepted_count;
    logic [CNT_W-1:0]      drop_count;
    logic                  overflow;

    int tests_run = 0;
    int tests_failed = 0;

    // reference model state
    eth_metadata_t mq[$];
    eth_metadata_t exp_out[$];
    eth_metadata_t got[$];
    int  m_acc, m_drop;
    bit  m_ovf, m_prev;

    metadata_egress_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .metadata(metadata), .metadata_valid(metadata_valid),
        .m_metadata(m_metadata), .m_valid(m_valid), .m_ready(m_ready),
        .occupancy(occupancy), .full(full), .accepted_count(accepted_count),
        .drop_count(drop_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic eth_metadata_t mk(input int k);
        eth_metadata_t r;
        r.dest_mac  = 48'(k);
        r.src_mac   = {16'(($urandom)), 32'($urandom)};
        r.ethertype = 16'h0800;
        r.frame_len = 16'($urandom_range(64, 1518));
        return r;
    endfunction

    // Advance one clock: record what the DUT hands out, update the model from the
    // queue rules, then settle 1 time unit past the edge.
    task automatic step();
        bit cap, pop;
        if (rst_n && m_valid && m_ready) got.push_back(m_metadata);
        if (!rst_n) begin
            mq.delete(); m_acc = 0; m_drop = 0; m_ovf = 0; m_prev = 0;
        end else begin
            cap    = metadata_valid && !m_prev;
            m_prev = metadata_valid;
            pop    = (mq.size() != 0) && m_ready;
            if (pop) exp_out.push_back(mq.pop_front());
            if (cap) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(metadata);
                    if (m_acc < CMAX) m_acc++;
                end else begin
                    if (m_drop < CMAX) m_drop++;
                    m_ovf = 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; metadata_valid = 1'b0; m_ready = 1'b0;
        step();
        rst_n = 1'b1;
        got.delete(); exp_out.delete();
    endtask

    task automatic pulse(input int k);
        metadata = mk(k); metadata_valid = 1'b1; step();
        metadata_valid = 1'b0; step();
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_m_valid got %0b exp 0", m_valid); end
        tests_run++; if (occupancy !== '0) begin tests_failed++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
        tests_run++; if (full !== 1'b0) begin tests_failed++; $display("FAIL reset_full got %0b exp 0", full); end
        tests_run++; if (accepted_count !== '0) begin tests_failed++; $display("FAIL reset_acc got %0d exp 0", accepted_count); end
        tests_run++; if (drop_count !== '0) begin tests_failed++; $display("FAIL reset_drop got %0d exp 0", drop_count); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf got %0b exp 0", overflow); end
    endtask

    task automatic test_basic();
        do_reset();
        m_ready = 1'b1;
        metadata = mk(0); metadata.dest_mac = 48'h0011_2233_4455;
        metadata_valid = 1'b1;
        repeat (3) step();
        metadata_valid = 1'b0;
        repeat (3) step();
        tests_run++; if (got.size() != 1) begin tests_failed++; $display("FAIL basic_count got %0d exp 1", got.size()); end
        else begin
            tests_run++; if (got[0].dest_mac !== 48'h0011_2233_4455) begin tests_failed++; $display("FAIL basic_mac got %h exp 001122334455", got[0].dest_mac); end
        end
        tests_run++; if (accepted_count !== 16'd1) begin tests_failed++; $display("FAIL basic_acc got %0d exp 1", accepted_count); end
        tests_run++; if (occupancy !== '0) begin tests_failed++; $display("FAIL basic_occ got %0d exp 0", occupancy); end
    endtask

    task automatic test_level_hold();
        do_reset();
        m_ready = 1'b1;
        metadata = mk(7); metadata_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            metadata = mk(100 + i);
        end
        metadata_valid = 1'b0;
        repeat (2) step();
        tests_run++; if (accepted_count !== 16'd1) begin tests_failed++; $display("FAIL hold_acc got %0d exp 1", accepted_count); end
        tests_run++; if (got.size() != 1) begin tests_failed++; $display("FAIL hold_count got %0d exp 1", got.size()); end
        else begin
            tests_run++; if (got[0].dest_mac !== 48'd7) begin tests_failed++; $display("FAIL hold_mac got %0d exp 7", got[0].dest_mac); end
        end
    endtask

    task automatic test_fill_drop();
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            pulse(k);
            if (k == 4) begin
                tests_run++; if (full !== 1'b1) begin tests_failed++; $display("FAIL fill_full got %0b exp 1", full); end
            end
        end
        tests_run++; if (drop_count !== 16'd2) begin tests_failed++; $display("FAIL fill_drop got %0d exp 2", drop_count); end
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL fill_ovf got %0b exp 1", overflow); end
        tests_run++; if (accepted_count !== 16'd4) begin tests_failed++; $display("FAIL fill_acc got %0d exp 4", accepted_count); end
        m_ready = 1'b1;
        repeat (6) step();
        tests_run++; if (got.size() != 4) begin tests_failed++; $display("FAIL drain_count got %0d exp 4", got.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++; if (got[i].dest_mac !== 48'(i + 1)) begin tests_failed++; $display("FAIL drain_order[%0d] got %0d exp %0d", i, got[i].dest_mac, i + 1); end
            end
        end
        tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL drain_empty got %0b exp 0", m_valid); end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int k = 1; k <= 4; k++) pulse(k);
        metadata = mk(9); metadata_valid = 1'b1; m_ready = 1'b1;
        step();
        tests_run++; if (occupancy !== 3'd4) begin tests_failed++; $display("FAIL fullpop_occ got %0d exp 4", occupancy); end
        tests_run++; if (drop_count !== 16'd0) begin tests_failed++; $display("FAIL fullpop_drop got %0d exp 0", drop_count); end
        tests_run++; if (accepted_count !== 16'd5) begin tests_failed++; $display("FAIL fullpop_acc got %0d exp 5", accepted_count); end
        metadata_valid = 1'b0;
        repeat (6) step();
        tests_run++; if (got.size() != 5) begin tests_failed++; $display("FAIL fullpop_count got %0d exp 5", got.size()); end
        else begin
            tests_run++; if (got[4].dest_mac !== 48'd9) begin tests_failed++; $display("FAIL fullpop_last got %0d exp 9", got[4].dest_mac); end
        end
    endtask

    task automatic test_wrap_backpressure();
        eth_metadata_t held;
        bit chk;
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            for (int ph = 0; ph < 2; ph++) begin
                metadata_valid = (ph == 0);
                if (ph == 0) metadata = mk(k);
                m_ready = (ph == 0);
                chk  = m_valid && !m_ready;
                held = m_metadata;
                step();
                if (chk) begin
                    tests_run++;
                    if (m_valid !== 1'b1 || m_metadata !== held) begin
                        tests_failed++; $display("FAIL wrap_stable k=%0d got %h exp %h", k, m_metadata.dest_mac, held.dest_mac);
                    end
                end
            end
        end
        metadata_valid = 1'b0; m_ready = 1'b1;
        repeat (5) step();
        tests_run++; if (got.size() != 10) begin tests_failed++; $display("FAIL wrap_count got %0d exp 10", got.size()); end
        else begin
            for (int i = 0; i < 10; i++) begin
                tests_run++; if (got[i].dest_mac !== 48'(i + 1)) begin tests_failed++; $display("FAIL wrap_order[%0d] got %0d exp %0d", i, got[i].dest_mac, i + 1); end
            end
        end
        tests_run++; if (drop_count !== 16'd0) begin tests_failed++; $display("FAIL wrap_drop got %0d exp 0", drop_count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 1; k <= 5; k++) pulse(k);
        m_ready = 1'b1; step(); m_ready = 1'b0; step();
        tests_run++; if (occupancy !== 3'd3 || overflow !== 1'b1) begin tests_failed++; $display("FAIL mid_setup occ %0d ovf %0b exp 3 1", occupancy, overflow); end
        metadata = mk(42); metadata_valid = 1'b1; rst_n = 1'b0;
        step();
        tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_m_valid got %0b exp 0", m_valid); end
        tests_run++; if (occupancy !== '0) begin tests_failed++; $display("FAIL mid_occ got %0d exp 0", occupancy); end
        tests_run++; if (accepted_count !== '0 || drop_count !== '0) begin tests_failed++; $display("FAIL mid_counts got %0d %0d exp 0 0", accepted_count, drop_count); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL mid_ovf got %0b exp 0", overflow); end
        rst_n = 1'b1;
        repeat (6) step();
        tests_run++; if (accepted_count !== 16'd1) begin tests_failed++; $display("FAIL mid_recapture_acc got %0d exp 1", accepted_count); end
        tests_run++; if (occupancy !== 3'd1 || m_metadata.dest_mac !== 48'd42) begin tests_failed++; $display("FAIL mid_recapture occ %0d mac %0d exp 1 42", occupancy, m_metadata.dest_mac); end
        metadata_valid = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            metadata       = mk(1000 + c);
            metadata_valid = ($urandom_range(0, 1) == 1);
            m_ready        = ($urandom_range(0, 2) == 0);
            step();
            tests_run++;
            if (occupancy !== 3'(mq.size()) || m_valid !== (mq.size() != 0) || full !== (mq.size() == DEPTH)) begin
                tests_failed++; $display("FAIL rand_occ c=%0d got occ %0d v %0b f %0b exp occ %0d", c, occupancy, m_valid, full, mq.size());
            end
            tests_run++;
            if (accepted_count !== 16'(m_acc) || drop_count !== 16'(m_drop) || overflow !== m_ovf) begin
                tests_failed++; $display("FAIL rand_stats c=%0d got %0d %0d %0b exp %0d %0d %0b", c, accepted_count, drop_count, overflow, m_acc, m_drop, m_ovf);
            end
            if (mq.size() != 0) begin
                tests_run++;
                if (m_metadata !== mq[0]) begin tests_failed++; $display("FAIL rand_head c=%0d got %h exp %h", c, m_metadata, mq[0]); end
            end
        end
        metadata_valid = 1'b0; m_ready = 1'b1;
        repeat (DEPTH + 2) step();
        tests_run++;
        if (got.size() != exp_out.size()) begin
            tests_failed++; $display("FAIL rand_out_count got %0d exp %0d", got.size(), exp_out.size());
        end else begin
            for (int i = 0; i < got.size(); i++) begin
                tests_run++;
                if (got[i] !== exp_out[i]) begin tests_failed++; $display("FAIL rand_out[%0d] got %h exp %h", i, got[i], exp_out[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_level_hold();
        test_fill_drop();
        test_full_pop();
        test_wrap_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
